// File: rtl/inv_key_schedule.sv
// inv_key_schedule
//   Inverse AES-128 key schedule (10 rounds). Takes the round-10 key and
//   walks back to the round-0 (cipher) key. One round key is presented per
//   beat under a valid/ready handshake.
//
// Ports
//   clk        : clock, rising-edge active
//   rst        : asynchronous, active-high reset
//   start      : begin a schedule (honoured only while idle)
//   final_key  : round-10 key, w40 in [127:96] .. w43 in [31:0]
//   key_ready  : consumer accepts the presented round key
//   round_key  : current round key, same word order as final_key
//   round_idx  : round number of round_key (10 down to 0)
//   key_valid  : round_key/round_idx are valid
//   busy       : schedule in progress
//   done       : round-0 key is being presented
module inv_key_schedule (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [127:0] final_key,
  input  logic         key_ready,
  output logic [127:0] round_key,
  output logic [3:0]   round_idx,
  output logic         key_valid,
  output logic         busy,
  output logic         done
);

  typedef enum logic {IDLE, RUN} state_t;

  // Forward AES S-box, entry 0 in the most significant byte.
  localparam logic [2047:0] SBOX_BITS = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  // Entry b sits at bit offset 8*(255-b); for an 8-bit b, 255-b == ~b.
  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX_BITS[{~b, 3'b000} +: 8];
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  state_t       state;
  logic [127:0] key_q;
  logic [3:0]   idx_q;

  logic [31:0]  w0, w1, w2, w3;
  logic [31:0]  n0, n1, n2, n3;
  logic [7:0]   rcon;
  logic [127:0] prev_key;

  assign w0 = key_q[127:96];
  assign w1 = key_q[95:64];
  assign w2 = key_q[63:32];
  assign w3 = key_q[31:0];

  always_comb begin
    rcon = '0;
    case (idx_q)
      4'd1:    rcon = 8'h01;
      4'd2:    rcon = 8'h02;
      4'd3:    rcon = 8'h04;
      4'd4:    rcon = 8'h08;
      4'd5:    rcon = 8'h10;
      4'd6:    rcon = 8'h20;
      4'd7:    rcon = 8'h40;
      4'd8:    rcon = 8'h80;
      4'd9:    rcon = 8'h1b;
      4'd10:   rcon = 8'h36;
      default: rcon = 8'h00;
    endcase
  end

  // Undo one forward expansion step. The recovered last word of the
  // previous round (n3) feeds RotWord/SubWord to recover its first word.
  always_comb begin
    n3 = w3 ^ w2;
    n2 = w2 ^ w1;
    n1 = w1 ^ w0;
    n0 = w0 ^ sub_word({n3[23:0], n3[31:24]}) ^ {rcon, 24'h000000};
    prev_key = {n0, n1, n2, n3};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      key_q <= '0;
      idx_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state <= RUN;
            key_q <= final_key;
            idx_q <= 4'd10;
          end
        end
        RUN: begin
          if (key_ready) begin
            if (idx_q == 4'd0) begin
              // key and index (already 0) hold through IDLE
              state <= IDLE;
            end else begin
              key_q <= prev_key;
              idx_q <= idx_q - 4'd1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign round_key = key_q;
  assign round_idx = idx_q;
  assign key_valid = (state == RUN);
  assign busy      = (state == RUN);
  assign done      = (state == RUN) && (idx_q == 4'd0);

endmodule

// File: tb/tb_inv_key_schedule.sv
module tb_inv_key_schedule;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [127:0] final_key;
  logic         key_ready;
  logic [127:0] round_key;
  logic [3:0]   round_idx;
  logic         key_valid;
  logic         busy;
  logic         done;

  logic [134:0] obs;
  assign obs = {key_valid, busy, done, round_idx, round_key};

  int tests_run    = 0;
  int tests_failed = 0;

  localparam logic [127:0] KEY10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] KEY9  = 128'hac7766f319fadc2128d12941575c006e;
  localparam logic [127:0] KEY1  = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] KEY0  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] OTHER = 128'h00112233445566778899aabbccddeeff;

  logic [7:0]   sb [256];
  logic [127:0] ref_keys [11];

  inv_key_schedule dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .final_key (final_key),
    .key_ready (key_ready),
    .round_key (round_key),
    .round_idx (round_idx),
    .key_valid (key_valid),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1, "watchdog");
  end

  // GF(2^8) multiply, AES polynomial
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x, y;
    p = '0; x = a; y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
      y = y >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
    return (v << n) | (v >> (8 - n));
  endfunction

  function automatic logic [7:0] rcon_of(input int r);
    logic [7:0] rc;
    rc = 8'h01;
    for (int i = 1; i < r; i++) rc = rc[7] ? ((rc << 1) ^ 8'h1b) : (rc << 1);
    return rc;
  endfunction

  // Forward expansion: round r-1 key -> round r key
  function automatic logic [127:0] fwd_round(input logic [127:0] k, input int r);
    logic [31:0] w0, w1, w2, w3, t, n0, n1, n2, n3;
    w0 = k[127:96]; w1 = k[95:64]; w2 = k[63:32]; w3 = k[31:0];
    t  = {sb[w3[23:16]], sb[w3[15:8]], sb[w3[7:0]], sb[w3[31:24]]} ^ {rcon_of(r), 24'h0};
    n0 = w0 ^ t; n1 = w1 ^ n0; n2 = w2 ^ n1; n3 = w3 ^ n2;
    return {n0, n1, n2, n3};
  endfunction

  // S-box from multiplicative inverse plus affine transform
  task automatic build_model;
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = '0;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sb[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
    ref_keys[0] = KEY0;
    for (int r = 1; r <= 10; r++) ref_keys[r] = fwd_round(ref_keys[r-1], r);
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b0; key_ready = 1'b0; final_key = '0;
    #2;
    tests_run++;
    if (obs !== 135'd0) begin
      tests_failed++;
      $display("FAIL reset_async: got %h expected %h", obs, 135'd0);
    end
    start = 1'b1; final_key = KEY10;
    @(negedge clk);
    tests_run++;
    if (obs !== 135'd0) begin
      tests_failed++;
      $display("FAIL reset_clocked_start_ignored: got %h expected %h", obs, 135'd0);
    end
    start = 1'b0;
    rst = 1'b0;
  endtask

  // Full FIPS-197 sequence; optionally pulses start with another key in RUN,
  // including in the round-0 transfer cycle.
  task automatic test_fips(input bit pulse_start);
    logic [134:0] exp;
    int r;
    @(negedge clk);
    final_key = KEY10; start = 1'b1; key_ready = 1'b1;
    for (int b = 0; b < 11; b++) begin
      @(negedge clk);
      r = 10 - b;
      exp = {1'b1, 1'b1, 1'(r == 0), 4'(r), ref_keys[r]};
      tests_run++;
      if (obs !== exp) begin
        tests_failed++;
        $display("FAIL fips_beat%0d (pulse=%0d): got %h expected %h", r, pulse_start, obs, exp);
      end
      if (r == 10 || r == 9 || r == 1 || r == 0) begin
        tests_run++;
        if (round_key !== (r == 10 ? KEY10 : r == 9 ? KEY9 : r == 1 ? KEY1 : KEY0)) begin
          tests_failed++;
          $display("FAIL fips_vector_idx%0d: got %h expected %h", r, round_key,
                   (r == 10 ? KEY10 : r == 9 ? KEY9 : r == 1 ? KEY1 : KEY0));
        end
      end
      start = pulse_start && (b == 3 || b == 10);
      final_key = start ? OTHER : KEY10;
    end
    @(negedge clk);
    start = 1'b0;
    exp = {1'b0, 1'b0, 1'b0, 4'd0, KEY0};
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL fips_idle_after (pulse=%0d): got %h expected %h", pulse_start, obs, exp);
    end
    @(negedge clk);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL fips_idle_hold (pulse=%0d): got %h expected %h", pulse_start, obs, exp);
    end
  endtask

  task automatic test_backpressure;
    logic [134:0] exp;
    int  exp_idx, stall, beats;
    bit  finished;
    exp_idx = 10; stall = 0; beats = 0; finished = 1'b0;
    @(negedge clk);
    final_key = KEY10; start = 1'b1; key_ready = 1'b1;
    for (int c = 0; c < 40 && !finished; c++) begin
      @(negedge clk);
      start = 1'b0;
      beats++;
      exp = {1'b1, 1'b1, 1'(exp_idx == 0), 4'(exp_idx), ref_keys[exp_idx]};
      tests_run++;
      if (obs !== exp) begin
        tests_failed++;
        $display("FAIL bp_cycle%0d: got %h expected %h", c, obs, exp);
      end
      if (exp_idx == 7 && stall < 3) begin
        key_ready = 1'b0;
        stall++;
      end else begin
        key_ready = 1'b1;
        if (exp_idx == 0) finished = 1'b1;
        else exp_idx--;
      end
    end
    @(negedge clk);
    tests_run++;
    if (!finished || beats != 14 || key_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL bp_length: got beats=%0d finished=%0d valid=%b expected beats=14 finished=1 valid=0",
               beats, finished, key_valid);
    end
  endtask

  task automatic test_reset_mid_run;
    logic [134:0] exp;
    @(negedge clk);
    final_key = KEY10; start = 1'b1; key_ready = 1'b1;
    for (int b = 0; b < 6; b++) begin
      @(negedge clk);
      start = 1'b0;
    end
    tests_run++;
    if (round_idx !== 4'd5 || key_valid !== 1'b1) begin
      tests_failed++;
      $display("FAIL rst_mid_reach5: got idx=%0d valid=%b expected idx=5 valid=1", round_idx, key_valid);
    end
    #2 rst = 1'b1; start = 1'b1;
    #1;
    tests_run++;
    if (obs !== 135'd0) begin
      tests_failed++;
      $display("FAIL rst_mid_immediate: got %h expected %h", obs, 135'd0);
    end
    @(negedge clk);
    tests_run++;
    if (obs !== 135'd0) begin
      tests_failed++;
      $display("FAIL rst_mid_held: got %h expected %h", obs, 135'd0);
    end
    rst = 1'b0; start = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      tests_run++;
      if (obs !== 135'd0) begin
        tests_failed++;
        $display("FAIL rst_mid_idle%0d: got %h expected %h", c, obs, 135'd0);
      end
    end
    final_key = KEY10; start = 1'b1;
    for (int b = 0; b < 11; b++) begin
      @(negedge clk);
      start = 1'b0;
      exp = {1'b1, 1'b1, 1'(b == 10), 4'(10 - b), ref_keys[10 - b]};
      tests_run++;
      if (obs !== exp) begin
        tests_failed++;
        $display("FAIL rst_mid_restart_beat%0d: got %h expected %h", 10 - b, obs, exp);
      end
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back;
    logic [134:0] exp;
    @(negedge clk);
    final_key = KEY10; start = 1'b1; key_ready = 1'b1;
    for (int c = 1; c <= 23; c++) begin
      @(negedge clk);
      if (c <= 11)
        exp = {1'b1, 1'b1, 1'(c == 11), 4'(11 - c), ref_keys[11 - c]};
      else if (c == 12)
        exp = {1'b0, 1'b0, 1'b0, 4'd0, ref_keys[0]};
      else
        exp = {1'b1, 1'b1, 1'(c == 23), 4'(23 - c), ref_keys[23 - c]};
      tests_run++;
      if (obs !== exp) begin
        tests_failed++;
        $display("FAIL b2b_cycle%0d: got %h expected %h", c, obs, exp);
      end
    end
    start = 1'b0;
    @(negedge clk);
    tests_run++;
    if (key_valid !== 1'b0 || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL b2b_end_idle: got valid=%b busy=%b expected 0 0", key_valid, busy);
    end
  endtask

  task automatic test_zero_key;
    logic [127:0] got [11];
    logic [127:0] k;
    @(negedge clk);
    final_key = '0; start = 1'b1; key_ready = 1'b1;
    for (int b = 0; b < 11; b++) begin
      @(negedge clk);
      start = 1'b0;
      got[10 - b] = round_key;
      tests_run++;
      if (key_valid !== 1'b1 || round_idx !== 4'(10 - b) || done !== 1'(b == 10)) begin
        tests_failed++;
        $display("FAIL zero_ctrl_beat%0d: got valid=%b idx=%0d done=%b expected 1 %0d %b",
                 10 - b, key_valid, round_idx, done, 10 - b, b == 10);
      end
    end
    tests_run++;
    if (got[10] !== 128'd0) begin
      tests_failed++;
      $display("FAIL zero_idx10: got %h expected %h", got[10], 128'd0);
    end
    k = got[0];
    for (int r = 1; r <= 10; r++) begin
      k = fwd_round(k, r);
      tests_run++;
      if (got[r] !== k) begin
        tests_failed++;
        $display("FAIL zero_fwd_round%0d: got %h expected %h", r, got[r], k);
      end
    end
    tests_run++;
    if (k !== 128'd0) begin
      tests_failed++;
      $display("FAIL zero_fwd_to_zero: got %h expected %h", k, 128'd0);
    end
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; key_ready = 1'b0; final_key = '0;
    build_model();
    test_reset();
    test_fips(1'b0);
    test_fips(1'b1);
    test_backpressure();
    test_reset_mid_run();
    test_back_to_back();
    test_zero_key();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/inv_key_schedule.md
INV_KEY_SCHEDULE -- requirements
Module: inv_key_schedule

Interface
REQ-001 SHALL have one clock and one reset; reset is asynchronous and active-high.
REQ-002 SHALL have no parameters; the block is fixed to AES-128, 10 rounds.
REQ-003 clk  input  1  clock; all state updates on its rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 start  input  1  request to begin an inverse schedule; sampled only in IDLE.
REQ-006 final_key  input  128  round-10 key, word w40 in [127:96] through w43 in [31:0]; sampled on the accepted start.
REQ-007 key_ready  input  1  consumer accepts the current round key.
REQ-008 round_key  output  128  current round key, same word order as final_key.
REQ-009 round_idx  output  4  round number of round_key, 10 down to 0.
REQ-010 key_valid  output  1  round_key/round_idx valid.
REQ-011 busy  output  1  schedule in progress.
REQ-012 done  output  1  high while the round-0 key is presented.

Function
REQ-013 SHALL implement FSM states IDLE and RUN.
REQ-014 IDLE -> RUN on a rising edge with start=1; final_key is loaded into the key register and 10 is loaded into the index register on that same edge.
REQ-015 In the first RUN cycle, SHALL present key_valid=1, busy=1, round_idx=10, round_key=final_key (1-cycle latency from start).
REQ-016 Transfer = a cycle where key_valid=1 and key_ready=1; round_key and round_idx SHALL hold stable while key_valid=1 and key_ready=0.
REQ-017 On a transfer with round_idx=r>0, the next cycle SHALL present round r-1 computed by inverse expansion: w3'=w3^w2, w2'=w2^w1, w1'=w1^w0, w0'=w0^SubWord(RotWord(w3'))^Rcon(r).
REQ-018 Rcon(r) for r=1..10 SHALL be 01,02,04,08,10,20,40,80,1b,36 in the top byte, with the lower three bytes zero.
REQ-019 RotWord SHALL rotate bytes left by one, e.g. {a,b,c,d} -> {b,c,d,a}; SubWord SHALL apply the forward AES S-box to each byte.
REQ-020 Exactly one round step SHALL be computed per transfer; the S-box and XOR logic are combinational from the key register.
REQ-021 done SHALL be 1 exactly when key_valid=1 and round_idx=0.
REQ-022 A transfer with round_idx=0 SHALL return the FSM to IDLE; in the next cycle key_valid=0, busy=0, done=0.
REQ-023 start SHALL be ignored in RUN, including in the cycle of the round-0 transfer; a new schedule needs start while in IDLE.
REQ-024 In IDLE, round_key SHALL hold its last value, round_idx SHALL hold 0, and key_valid, done and busy SHALL be 0.
REQ-025 The index SHALL never wrap below 0 or exceed 10.

Reset
REQ-026 While rst=1: state=IDLE, round_key=0, round_idx=0, key_valid=0, busy=0, done=0, regardless of clk.
REQ-027 rst asserted mid-RUN SHALL abort the schedule immediately; after deassertion the block idles until a new start.
REQ-028 start SHALL be ignored in any cycle where rst=1.

Verification
REQ-029 FIPS-197 A.1: start with final_key=d014f9a8c9ee2589e13f0cc8b6630ca6 and key_ready=1 -> idx10 = that key; idx9=ac7766f319fadc2128d12941575c006e; idx1=a0fafe1788542cb123a339392a6c7605; idx0=2b7e151628aed2a6abf7158809cf4f3c with done=1; 11 valid cycles total.
REQ-030 Backpressure: key_ready=0 for 3 cycles at idx 7 -> round_key/round_idx are stable for those cycles, and the sequence resumes with identical values.
REQ-031 start pulsed during RUN with a different final_key -> ignored; the sequence matches REQ-029.
REQ-032 rst pulsed at idx 5 -> outputs go to 0 immediately; a new start then produces the full sequence from idx 10.
REQ-033 start held high continuously with key_ready=1 -> back-to-back schedules, with one IDLE cycle (key_valid=0) between the idx-0 beat and the next idx-10 beat.
REQ-034 All-zero final_key -> idx0 output equals the key whose forward expansion yields all-zero at round 10; checked against the bench's forward-expansion model.
